// File: rtl/lcd_hd44780_if.sv
// Request/LCD-pin bundle for the HD44780 controller: the requester drives the
// byte handshake, the controller drives the LCD pins, status and debug state.
interface lcd_hd44780_if #(
    parameter int BUS_WIDTH = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_rs;
    logic [7:0]           in_byte;
    logic                 init_done;
    logic                 lcd_rs;
    logic                 lcd_rw;
    logic                 lcd_e;
    logic [BUS_WIDTH-1:0] lcd_data;
    logic [2:0]           dbg_state;

    // Handshake: a byte moves on the rising edge where in_valid & in_ready are
    // both high; the requester holds in_valid/in_rs/in_byte stable until then.
    modport master (
        output in_valid, in_rs, in_byte,
        input  in_ready, init_done, lcd_rs, lcd_rw, lcd_e, lcd_data, dbg_state
    );

    modport slave (
        input  in_valid, in_rs, in_byte,
        output in_ready, init_done, lcd_rs, lcd_rw, lcd_e, lcd_data, dbg_state
    );
endinterface

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 character-LCD controller: autonomous power-on init, then byte writes
// over valid/ready, with E-strobe and busy-wait timing counted in system clocks.
module lcd_hd44780_ctrl #(
    parameter int BUS_WIDTH    = 4,
    parameter int PWRUP_CYC    = 600000,
    parameter int E_HIGH_CYC   = 20,
    parameter int CMD_WAIT_CYC = 1600,
    parameter int CLR_WAIT_CYC = 65600
) (
    input logic          clk,
    input logic          rst,
    lcd_hd44780_if.slave lcd_if
);
    localparam int MAX_A     = (PWRUP_CYC > CLR_WAIT_CYC) ? PWRUP_CYC : CLR_WAIT_CYC;
    localparam int MAX_B     = (CMD_WAIT_CYC > E_HIGH_CYC) ? CMD_WAIT_CYC : E_HIGH_CYC;
    localparam int MAXP      = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW        = $clog2(MAXP + 1);
    localparam int STEP_LAST = (BUS_WIDTH == 4) ? 7 : 6;

    if (BUS_WIDTH != 4 && BUS_WIDTH != 8) begin : g_bad_width
        $error("lcd_hd44780_ctrl: BUS_WIDTH must be 4 or 8");
    end

    // Init writes reuse the transfer states; the init phase is init_done_q == 0.
    typedef enum logic [2:0] {
        S_PWRUP, S_IDLE, S_SETUP, S_EHI, S_ELO, S_WAIT
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [7:0]           byte_q, byte_d;
    logic                 rs_q, rs_d;
    logic                 wake_q, wake_d;
    logic                 single_q, single_d;
    logic                 nib_q, nib_d;
    logic [2:0]           step_q, step_d;
    logic                 init_done_q, init_done_d;
    logic                 in_ready_q, in_ready_d;
    logic                 lcd_e_q, lcd_e_d;
    logic                 lcd_rs_q, lcd_rs_d;
    logic [BUS_WIDTH-1:0] lcd_data_q, lcd_data_d;

    logic                 ld;
    logic [7:0]           ld_byte;
    logic                 ld_rs, ld_wake, ld_single;
    logic [2:0]           step_nxt;

    function automatic logic [7:0] step_byte(input logic [2:0] s);
        logic [7:0] b;
        if (BUS_WIDTH == 4) begin
            case (s)
                3'd0, 3'd1, 3'd2: b = 8'h30;
                3'd3:             b = 8'h20;
                3'd4:             b = 8'h28;
                3'd5:             b = 8'h0C;
                3'd6:             b = 8'h01;
                default:          b = 8'h06;
            endcase
        end else begin
            case (s)
                3'd0, 3'd1, 3'd2: b = 8'h30;
                3'd3:             b = 8'h38;
                3'd4:             b = 8'h0C;
                3'd5:             b = 8'h01;
                default:          b = 8'h06;
            endcase
        end
        return b;
    endfunction

    function automatic logic [CW-1:0] wait_load(input logic wake, input logic rs,
                                                input logic [7:0] b);
        if (wake || (!rs && (b == 8'h01 || b == 8'h02 || b == 8'h03)))
            return CW'(CLR_WAIT_CYC - 1);
        return CW'(CMD_WAIT_CYC - 1);
    endfunction

    assign step_nxt = step_q + 3'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        byte_d      = byte_q;
        rs_d        = rs_q;
        wake_d      = wake_q;
        single_d    = single_q;
        nib_d       = nib_q;
        step_d      = step_q;
        init_done_d = init_done_q;
        in_ready_d  = in_ready_q;
        lcd_e_d     = lcd_e_q;
        lcd_rs_d    = lcd_rs_q;
        lcd_data_d  = lcd_data_q;
        ld          = 1'b0;
        ld_byte     = 8'h00;
        ld_rs       = 1'b0;
        ld_wake     = 1'b0;
        ld_single   = 1'b0;

        case (state_q)
            S_PWRUP: begin
                if (cnt_q == '0) begin
                    ld        = 1'b1;
                    ld_byte   = step_byte(3'd0);
                    ld_wake   = 1'b1;
                    ld_single = 1'b1;
                    step_d    = 3'd0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_IDLE: begin
                if (lcd_if.in_valid && in_ready_q) begin
                    ld         = 1'b1;
                    ld_byte    = lcd_if.in_byte;
                    ld_rs      = lcd_if.in_rs;
                    in_ready_d = 1'b0;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_EHI;
                    cnt_d   = CW'(E_HIGH_CYC - 1);
                    lcd_e_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_EHI: begin
                if (cnt_q == '0) begin
                    state_d = S_ELO;
                    cnt_d   = CW'(E_HIGH_CYC - 1);
                    lcd_e_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_ELO: begin
                if (cnt_q == '0) begin
                    if (BUS_WIDTH == 4 && !single_q && !nib_q) begin
                        nib_d      = 1'b1;
                        lcd_data_d = byte_q[BUS_WIDTH-1:0];
                        state_d    = S_SETUP;
                        cnt_d      = CW'(1);
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = wait_load(wake_q, rs_q, byte_q);
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (init_done_q || step_q == 3'(STEP_LAST)) begin
                    state_d     = S_IDLE;
                    init_done_d = 1'b1;
                    in_ready_d  = 1'b1;
                end else begin
                    // Single-nibble writes (wake-ups and the 0x2 mode switch) are steps 0..3.
                    step_d    = step_nxt;
                    ld        = 1'b1;
                    ld_byte   = step_byte(step_nxt);
                    ld_wake   = (step_nxt < 3'd3);
                    ld_single = (BUS_WIDTH == 4) && (step_nxt <= 3'd3);
                end
            end
            default: state_d = S_PWRUP;
        endcase

        if (ld) begin
            byte_d     = ld_byte;
            rs_d       = ld_rs;
            wake_d     = ld_wake;
            single_d   = ld_single;
            nib_d      = 1'b0;
            lcd_rs_d   = ld_rs;
            lcd_data_d = ld_byte[7 -: BUS_WIDTH];
            state_d    = S_SETUP;
            cnt_d      = CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_PWRUP;
            cnt_q       <= CW'(PWRUP_CYC - 1);
            byte_q      <= 8'h00;
            rs_q        <= 1'b0;
            wake_q      <= 1'b0;
            single_q    <= 1'b0;
            nib_q       <= 1'b0;
            step_q      <= 3'd0;
            init_done_q <= 1'b0;
            in_ready_q  <= 1'b0;
            lcd_e_q     <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            byte_q      <= byte_d;
            rs_q        <= rs_d;
            wake_q      <= wake_d;
            single_q    <= single_d;
            nib_q       <= nib_d;
            step_q      <= step_d;
            init_done_q <= init_done_d;
            in_ready_q  <= in_ready_d;
            lcd_e_q     <= lcd_e_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_data_q  <= lcd_data_d;
        end
    end

    assign lcd_if.in_ready  = in_ready_q;
    assign lcd_if.init_done = init_done_q;
    assign lcd_if.lcd_rs    = lcd_rs_q;
    assign lcd_if.lcd_rw    = 1'b0;
    assign lcd_if.lcd_e     = lcd_e_q;
    assign lcd_if.lcd_data  = lcd_data_q;
    assign lcd_if.dbg_state = state_q;
endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Bench for lcd_hd44780_ctrl: 4-bit and 8-bit instances side by side, with a
// strobe scoreboard per instance and directed latency/init-timing checks.
module tb_lcd_hd44780_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic [4:0] exp4_q[$];
    logic [8:0] exp8_q[$];

    lcd_hd44780_if #(.BUS_WIDTH(4)) if4 ();
    lcd_hd44780_if #(.BUS_WIDTH(8)) if8 ();

    lcd_hd44780_ctrl #(.BUS_WIDTH(4), .PWRUP_CYC(100), .E_HIGH_CYC(4),
                       .CMD_WAIT_CYC(20), .CLR_WAIT_CYC(50))
        dut4 (.clk(clk), .rst(rst), .lcd_if(if4));

    lcd_hd44780_ctrl #(.BUS_WIDTH(8), .PWRUP_CYC(100), .E_HIGH_CYC(4),
                       .CMD_WAIT_CYC(20), .CLR_WAIT_CYC(50))
        dut8 (.clk(clk), .rst(rst), .lcd_if(if8));

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Strobe monitors: pop on each E rise, then check pulse width and hold.
    initial begin
        logic       prev_e = 1'b0;
        int         w = 0;
        logic [4:0] cur = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_e = 1'b0;
                w = 0;
            end else begin
                if (if4.lcd_e && !prev_e) begin
                    cur = {if4.lcd_rs, if4.lcd_data};
                    w = 1;
                    if (exp4_q.size() == 0) chk("strobe4_extra", int'(cur), 'h100);
                    else chk("strobe4_data", int'(cur), int'(exp4_q.pop_front()));
                end else if (if4.lcd_e) begin
                    w++;
                end else if (prev_e) begin
                    chk("e4_width", w, 4);
                    chk("hold4", int'({if4.lcd_rs, if4.lcd_data}), int'(cur));
                end
                prev_e = if4.lcd_e;
            end
        end
    end

    initial begin
        logic       prev_e = 1'b0;
        int         w = 0;
        logic [8:0] cur = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_e = 1'b0;
                w = 0;
            end else begin
                if (if8.lcd_e && !prev_e) begin
                    cur = {if8.lcd_rs, if8.lcd_data};
                    w = 1;
                    if (exp8_q.size() == 0) chk("strobe8_extra", int'(cur), 'h1000);
                    else chk("strobe8_data", int'(cur), int'(exp8_q.pop_front()));
                end else if (if8.lcd_e) begin
                    w++;
                end else if (prev_e) begin
                    chk("e8_width", w, 4);
                    chk("hold8", int'({if8.lcd_rs, if8.lcd_data}), int'(cur));
                end
                prev_e = if8.lcd_e;
            end
        end
    end

    task automatic push_init();
        logic [3:0] n4 [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                                4'h0, 4'hC, 4'h0, 4'h1, 4'h0, 4'h6};
        logic [7:0] b8 [7]  = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h0C, 8'h01, 8'h06};
        exp4_q.delete();
        exp8_q.delete();
        for (int i = 0; i < 12; i++) exp4_q.push_back({1'b0, n4[i]});
        for (int i = 0; i < 7; i++) exp8_q.push_back({1'b0, b8[i]});
    endtask

    task automatic chk_rst_outputs(input string tag);
        chk({tag, "_ready4"}, int'(if4.in_ready), 0);
        chk({tag, "_done4"},  int'(if4.init_done), 0);
        chk({tag, "_e4"},     int'(if4.lcd_e), 0);
        chk({tag, "_data4"},  int'(if4.lcd_data), 0);
        chk({tag, "_rs4"},    int'(if4.lcd_rs), 0);
        chk({tag, "_rw4"},    int'(if4.lcd_rw), 0);
        chk({tag, "_ready8"}, int'(if8.in_ready), 0);
        chk({tag, "_done8"},  int'(if8.init_done), 0);
        chk({tag, "_e8"},     int'(if8.lcd_e), 0);
        chk({tag, "_data8"},  int'(if8.lcd_data), 0);
    endtask

    // Called right after rst is released on a negedge.
    task automatic wait_init(input bit hold_valid);
        int n = 0;
        int n4 = -1;
        int n8 = -1;
        if (hold_valid) begin
            if4.in_valid = 1'b1;
            if4.in_rs    = 1'b1;
            if4.in_byte  = 8'h55;
        end
        while ((n4 < 0 || n8 < 0) && n < 3000) begin
            @(posedge clk);
            n++;
            #1;
            if (n4 < 0 && if4.init_done) n4 = n;
            if (n8 < 0 && if8.init_done) n8 = n;
            if (n == 250) chk("init4_ready_low", int'(if4.in_ready), 0);
            if (n == 400) if4.in_valid = 1'b0;
        end
        chk("init4_cycles", n4, 500);
        chk("init8_cycles", n8, 430);
        chk("init4_ready", int'(if4.in_ready), 1);
        chk("init8_ready", int'(if8.in_ready), 1);
        chk("init4_left", exp4_q.size(), 0);
        chk("init8_left", exp8_q.size(), 0);
        @(negedge clk);
    endtask

    // Start on a negedge; returns on a negedge after ready has come back.
    task automatic send(input bit w8, input bit rs, input logic [7:0] b, input int exp_n);
        int n = 0;
        if (w8) begin
            exp8_q.push_back({rs, b});
            if8.in_rs = rs; if8.in_byte = b; if8.in_valid = 1'b1;
        end else begin
            exp4_q.push_back({rs, b[7:4]});
            exp4_q.push_back({rs, b[3:0]});
            if4.in_rs = rs; if4.in_byte = b; if4.in_valid = 1'b1;
        end
        while (!(w8 ? if8.in_ready : if4.in_ready) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!(w8 ? if8.in_ready : if4.in_ready)) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        if8.in_valid = 1'b0;
        if4.in_valid = 1'b0;
        chk("ready_drop", int'(w8 ? if8.in_ready : if4.in_ready), 0);
        n = 0;
        while (!(w8 ? if8.in_ready : if4.in_ready) && n < 5000) begin
            @(posedge clk);
            n++;
            #1;
        end
        chk(w8 ? "latency8" : "latency4", n, exp_n);
        @(negedge clk);
    endtask

    task automatic stream4();
        int acc [4];
        int n;
        if4.in_valid = 1'b1;
        if4.in_rs    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if4.in_byte = 8'h30 + 8'(i);
            exp4_q.push_back({1'b1, 4'h3});
            exp4_q.push_back({1'b1, 4'(i)});
            n = 0;
            while (!if4.in_ready && n < 5000) begin
                @(negedge clk);
                n++;
            end
            @(posedge clk);
            #1;
            acc[i] = cyc;
            if (i > 0) chk("accept_gap", acc[i] - acc[i-1], 41);
        end
        if4.in_valid = 1'b0;
        n = 0;
        while (!if4.in_ready && n < 5000) begin
            @(posedge clk);
            n++;
            #1;
        end
        chk("stream_last_latency", n, 40);
        chk("stream_left", exp4_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        int n;
        if4.in_valid = 1'b0; if4.in_rs = 1'b0; if4.in_byte = 8'h00;
        if8.in_valid = 1'b0; if8.in_rs = 1'b0; if8.in_byte = 8'h00;
        repeat (3) @(negedge clk);
        chk_rst_outputs("reset");
        push_init();
        rst = 1'b0;
        wait_init(1'b0);

        send(1'b0, 1'b1, 8'h41, 40);
        send(1'b0, 1'b0, 8'h01, 70);
        send(1'b0, 1'b0, 8'h0C, 40);
        send(1'b1, 1'b1, 8'h41, 30);
        send(1'b1, 1'b0, 8'h02, 60);
        chk("send4_left", exp4_q.size(), 0);
        chk("send8_left", exp8_q.size(), 0);

        stream4();

        // Abort a byte mid-strobe; only its first nibble ever reaches the pins.
        exp4_q.push_back({1'b1, 4'h5});
        if4.in_rs = 1'b1; if4.in_byte = 8'h5A; if4.in_valid = 1'b1;
        @(posedge clk);
        #1;
        if4.in_valid = 1'b0;
        n = 0;
        while (!if4.lcd_e && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("abort_e_seen", int'(if4.lcd_e), 1);
        #2;
        rst = 1'b1;
        #1;
        chk_rst_outputs("abort");
        chk("abort_left", exp4_q.size(), 0);
        push_init();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_init(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
